alu_arbiter: RTL
================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL provide parameter SETTLE_CYCLES, default 4, number of clk cycles the ALU is given to settle after operand load (legal 1..255).
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port reset  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port req_valid  input  2  per-requester request valid (bit i = requester i).
REQ-005 SHALL have port req_ready  output  2  per-requester accept; at most one bit high.
REQ-006 SHALL have ports req0_a, req0_b  input  32 each  requester 0 operands.
REQ-007 SHALL have port req0_cmd  input  3  requester 0 ALU command.
REQ-008 SHALL have ports req1_a, req1_b  input  32 each  requester 1 operands.
REQ-009 SHALL have port req1_cmd  input  3  requester 1 ALU command.
REQ-010 SHALL have port rsp_valid  output  1  response valid.
REQ-011 SHALL have port rsp_ready  input  1  response consumer ready.
REQ-012 SHALL have port rsp_id  output  1  index of the requester owning the response.
REQ-013 SHALL have port rsp_result  output  32  captured ALU result.
REQ-014 SHALL have ports rsp_carryout, rsp_zero, rsp_overflow  output  1 each  captured ALU flags.
REQ-015 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-016 SHALL implement FSM states IDLE, SETTLE, RESP.
REQ-017 In IDLE with any req_valid bit set, SHALL assert the granted req_ready bit combinationally; on that edge: latch operands, command and id into op registers, load the settle counter with SETTLE_CYCLES-1, go to SETTLE.
REQ-018 SHALL hold req_ready = 2'b00 in SETTLE and RESP.
REQ-019 SHALL drive ALU inputs only from op registers, never directly from request ports.
REQ-020 In SETTLE, SHALL decrement the counter each cycle; when it reaches 0, capture ALU outputs into the rsp registers, set rsp_valid, go to RESP.
REQ-021 Latency: rsp_valid SHALL rise exactly SETTLE_CYCLES cycles after the accept edge.
REQ-022 In RESP, rsp_* SHALL stay stable while rsp_valid && !rsp_ready; on the rsp_valid && rsp_ready edge, clear rsp_valid and go to IDLE.
REQ-023 SHALL NOT accept a request in the cycle the response handshakes; peak throughput is one op per SETTLE_CYCLES+2 cycles.
REQ-024 rsp_result and flags SHALL retain their last value after the handshake until the next capture.
REQ-025 A single valid requester SHALL be granted immediately, independent of arbitration state.
REQ-026 A requester dropping req_valid before it is granted SHALL have no effect.

Reset
REQ-027 While reset is high, SHALL force state IDLE, all outputs 0, counter 0, op and rsp registers 0, round-robin pointer = 1 (requester 0 wins the first tie).
REQ-028 Reset mid-operation SHALL abort the transaction; no rsp_valid for it is ever emitted.

Configuration
REQ-029 With ALU_ARB_RR_EN defined, ties SHALL go to the requester not granted last; the pointer updates only on accept.
REQ-030 Without ALU_ARB_RR_EN, ties SHALL always go to requester 0, and no pointer register SHALL exist.

Structure
REQ-031 Shared package alu_pkg SHALL hold command codes ADD=000, SUB=001, XOR=010, SLT=011, AND=100, NAND=101, NOR=110, OR=111, the FSM state encoding, and the default settle constant.
REQ-032 SHALL contain exactly one sub-module: one instance of the existing ALU (result, carryout, zero, overflow, operandA, operandB, command).

Verification
REQ-033 req_valid=01, req0 a=1, b=2, cmd=SLT -> req_ready=01 same cycle; 4 cycles later rsp_valid=1, rsp_result=1, rsp_zero=0, rsp_id=0.
REQ-034 (RR) both valid; req0 ADD 0xFFFFFFFF+1, req1 SUB 5-7 -> first rsp id=0, result=0, carryout=1, zero=1; then id=1, result=0xFFFFFFFE; next tie grants req1.
REQ-035 rsp_ready=0 for 10 cycles in RESP -> rsp_* stable, req_ready=00, busy=1; rsp_ready=1 -> IDLE next cycle.
REQ-036 ADD 0x7FFFFFFF+1 -> result=0x80000000, overflow=1, carryout=0.
REQ-037 reset pulsed during the 2nd SETTLE cycle -> rsp_valid never rises, all outputs 0; the next request completes normally.
REQ-038 (no macro) both req_valid held high for 3 transactions -> rsp_id=0 every time.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter: ALU command codes, arbiter FSM states and
// the default settle time.
package alu_pkg;

  typedef enum logic [2:0] {
    CmdAdd  = 3'b000,
    CmdSub  = 3'b001,
    CmdXor  = 3'b010,
    CmdSlt  = 3'b011,
    CmdAnd  = 3'b100,
    CmdNand = 3'b101,
    CmdNor  = 3'b110,
    CmdOr   = 3'b111
  } alu_cmd_e;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StSettle = 2'd1,
    StResp   = 2'd2
  } alu_arb_state_e;

  localparam int unsigned SettleCyclesDefault = 4;
  localparam int unsigned CntWidth            = 8;

endpackage

// File: rtl/alu_arbiter_alu.sv
// 32-bit combinational ALU: add/sub/slt through one adder, plus bitwise ops.
// carryout and overflow are meaningful only for ADD and SUB; they read 0 otherwise.
module alu_arbiter_alu
  import alu_pkg::*;
(
  output logic [31:0] result,
  output logic        carryout,
  output logic        zero,
  output logic        overflow,
  input  logic [31:0] operandA,
  input  logic [31:0] operandB,
  input  logic [2:0]  command
);

  alu_cmd_e    cmd;
  logic        is_sub;
  logic [31:0] b_eff;
  logic [32:0] sum;
  logic        add_ovf;

  assign cmd    = alu_cmd_e'(command);
  assign is_sub = (cmd == CmdSub) || (cmd == CmdSlt);
  assign b_eff  = is_sub ? ~operandB : operandB;
  assign sum    = {1'b0, operandA} + {1'b0, b_eff} + {32'd0, is_sub};
  // Signed overflow: operands of equal sign produce a sum of the other sign.
  assign add_ovf = (operandA[31] == b_eff[31]) && (sum[31] != operandA[31]);

  always_comb begin
    result   = '0;
    carryout = 1'b0;
    overflow = 1'b0;
    unique case (cmd)
      CmdAdd, CmdSub: begin
        result   = sum[31:0];
        carryout = sum[32];
        overflow = add_ovf;
      end
      CmdSlt:  result = {31'd0, sum[31] ^ add_ovf};
      CmdXor:  result = operandA ^ operandB;
      CmdAnd:  result = operandA & operandB;
      CmdNand: result = ~(operandA & operandB);
      CmdNor:  result = ~(operandA | operandB);
      CmdOr:   result = operandA | operandB;
      default: result = '0;
    endcase
  end

  assign zero = (result == 32'd0);

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester front end for a shared ALU: grant, latch operands, wait SETTLE_CYCLES,
// capture result and hold it until the consumer takes it. ALU_ARB_RR_EN enables round-robin ties.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = SettleCyclesDefault
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic [2:0]  req0_cmd,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic [2:0]  req1_cmd,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [31:0] rsp_result,
  output logic        rsp_carryout,
  output logic        rsp_zero,
  output logic        rsp_overflow,
  output logic        busy
);

  localparam logic [CntWidth-1:0] SettleLoad = CntWidth'(SETTLE_CYCLES - 1);

  alu_arb_state_e      state_q, state_d;
  logic [CntWidth-1:0] cnt_q;
  logic [31:0]         op_a_q, op_b_q;
  logic [2:0]          op_cmd_q;
  logic                op_id_q;

  logic                rsp_valid_q, rsp_id_q, rsp_carry_q, rsp_zero_q, rsp_ovf_q;
  logic [31:0]         rsp_result_q;

  logic                grant_id, accept, capture, handshake;
  logic [31:0]         alu_result;
  logic                alu_carry, alu_zero, alu_ovf;

`ifdef ALU_ARB_RR_EN
  // Remembers the last accepted requester; reset value 1 lets requester 0 win the first tie.
  logic last_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_q <= 1'b1;
    end else if (accept) begin
      last_q <= grant_id;
    end
  end

  assign grant_id = (&req_valid) ? ~last_q : req_valid[1];
`else
  assign grant_id = ~req_valid[0];
`endif

  always_comb begin
    state_d   = state_q;
    req_ready = 2'b00;
    accept    = 1'b0;
    capture   = 1'b0;
    handshake = 1'b0;
    unique case (state_q)
      StIdle: begin
        if ((|req_valid) && !reset) begin
          accept              = 1'b1;
          req_ready[grant_id] = 1'b1;
          state_d             = StSettle;
        end
      end
      StSettle: begin
        if (cnt_q == '0) begin
          capture = 1'b1;
          state_d = StResp;
        end
      end
      StResp: begin
        if (rsp_valid_q && rsp_ready) begin
          handshake = 1'b1;
          state_d   = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q        <= '0;
      op_a_q       <= '0;
      op_b_q       <= '0;
      op_cmd_q     <= '0;
      op_id_q      <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_result_q <= '0;
      rsp_carry_q  <= 1'b0;
      rsp_zero_q   <= 1'b0;
      rsp_ovf_q    <= 1'b0;
    end else begin
      if (accept) begin
        op_a_q   <= grant_id ? req1_a : req0_a;
        op_b_q   <= grant_id ? req1_b : req0_b;
        op_cmd_q <= grant_id ? req1_cmd : req0_cmd;
        op_id_q  <= grant_id;
        cnt_q    <= SettleLoad;
      end else if ((state_q == StSettle) && (cnt_q != '0)) begin
        cnt_q <= cnt_q - 1'b1;
      end

      // Result and flags are left untouched by the handshake so they stay readable.
      if (capture) begin
        rsp_valid_q  <= 1'b1;
        rsp_id_q     <= op_id_q;
        rsp_result_q <= alu_result;
        rsp_carry_q  <= alu_carry;
        rsp_zero_q   <= alu_zero;
        rsp_ovf_q    <= alu_ovf;
      end else if (handshake) begin
        rsp_valid_q <= 1'b0;
      end
    end
  end

  alu_arbiter_alu u_alu (
    .result   (alu_result),
    .carryout (alu_carry),
    .zero     (alu_zero),
    .overflow (alu_ovf),
    .operandA (op_a_q),
    .operandB (op_b_q),
    .command  (op_cmd_q)
  );

  assign rsp_valid    = rsp_valid_q;
  assign rsp_id       = rsp_id_q;
  assign rsp_result   = rsp_result_q;
  assign rsp_carryout = rsp_carry_q;
  assign rsp_zero     = rsp_zero_q;
  assign rsp_overflow = rsp_ovf_q;
  assign busy         = (state_q != StIdle);

endmodule
